// File: rtl/rom_fetch_arb.sv
// rom_fetch_arb: two-entry prefetch buffer sharing one combinational ROM port.
// Optional debug read arbitration is enabled by defining ROM_FETCH_DBG_EN.
module rom_fetch_arb #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  input  logic        dbg_req_i,
  input  logic [31:0] dbg_addr_i,
  output logic        dbg_gnt_o,
  output logic        dbg_rvalid_o,
  output logic [31:0] dbg_rdata_o
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_ent_t;

  fetch_ent_t  head_q;
  fetch_ent_t  tail_q;
  fetch_ent_t  new_ent;
  logic [1:0]  count_q;
  logic [31:0] fetch_pc_q;
  logic        pop;
  logic        need;
  logic        fetch_own;
  logic        dbg_gnt;
  logic        unused_jump_lsb;

  assign inst_valid_o = (count_q != 2'd0);
  assign inst_o       = head_q.inst;
  assign inst_pc_o    = head_q.pc;

  assign pop       = inst_valid_o & ~stall_i & ~jump_i;
  assign need      = ~jump_i & ((count_q < 2'd2) | pop);
  assign fetch_own = need & ~dbg_gnt;

  assign dbg_gnt_o  = dbg_gnt;
  assign rom_addr_o = dbg_gnt ? dbg_addr_i : fetch_pc_q;

  assign new_ent.pc   = fetch_pc_q;
  assign new_ent.inst = rom_inst_i;

  assign unused_jump_lsb = ^jump_addr_i[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
      fetch_pc_q <= RESET_PC;
    end else if (jump_i) begin
      count_q    <= 2'd0;
      fetch_pc_q <= {jump_addr_i[31:2], 2'b00};
    end else begin
      if (fetch_own)
        fetch_pc_q <= fetch_pc_q + 32'd4;
      case ({pop, fetch_own})
        2'b10: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd0)
            head_q <= new_ent;
          else
            tail_q <= new_ent;
          count_q <= count_q + 2'd1;
        end
        2'b11: begin
          // count is unchanged; full buffer shifts, single entry is replaced
          if (count_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= new_ent;
          end else begin
            head_q <= new_ent;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ROM_FETCH_DBG_EN
  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DBG   = 1'b1
  } owner_e;

  owner_e      owner_q;
  owner_e      owner_d;
  logic        dbg_rvalid_q;
  logic [31:0] dbg_rdata_q;

  // Debug steals the port only right after a fetch, and only if a buffered
  // instruction can cover the lost slot; this bounds fetch starvation to one cycle.
  assign dbg_gnt = rst_n & dbg_req_i &
                   (~need | (inst_valid_o & (owner_q == OWN_FETCH)));

  always_comb begin
    owner_d = owner_q;
    unique case (1'b1)
      dbg_gnt:   owner_d = OWN_DBG;
      fetch_own: owner_d = OWN_FETCH;
      default:   owner_d = owner_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q      <= OWN_FETCH;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= 32'd0;
    end else begin
      owner_q      <= owner_d;
      dbg_rvalid_q <= dbg_gnt;
      if (dbg_gnt)
        dbg_rdata_q <= rom_inst_i;
    end
  end

  assign dbg_rvalid_o = dbg_rvalid_q;
  assign dbg_rdata_o  = dbg_rdata_q;
`else
  logic unused_dbg;

  assign unused_dbg   = dbg_req_i ^ (^dbg_addr_i);
  assign dbg_gnt      = 1'b0;
  assign dbg_rvalid_o = 1'b0;
  assign dbg_rdata_o  = 32'd0;
`endif

endmodule

// File: doc/rom_fetch_arb.md
ROM_FETCH_ARB -- requirements
Module: rom_fetch_arb

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, fetch address loaded on reset.
REQ-002 Port: clk  in  1  single clock; all state on rising edge.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: rom_addr_o  out  32  byte address to the combinational ROM read port.
REQ-005 Port: rom_inst_i  in  32  ROM word at rom_addr_o, same cycle.
REQ-006 Port: stall_i  in  1  decode not ready; inhibits instruction pop.
REQ-007 Port: jump_i  in  1  redirect request, one-cycle pulse.
REQ-008 Port: jump_addr_i  in  32  redirect target.
REQ-009 Port: inst_o  out  32  head instruction of prefetch buffer.
REQ-010 Port: inst_pc_o  out  32  address of inst_o.
REQ-011 Port: inst_valid_o  out  1  inst_o/inst_pc_o valid.
REQ-012 Port: dbg_req_i  in  1  debug/data read request, held until granted.
REQ-013 Port: dbg_addr_i  in  32  debug read address.
REQ-014 Port: dbg_gnt_o  out  1  ROM port granted to debug this cycle (combinational).
REQ-015 Port: dbg_rvalid_o  out  1  debug read data valid.
REQ-016 Port: dbg_rdata_o  out  32  debug read data.

Function
REQ-017 Prefetch buffer SHALL be a 2-entry FIFO of {pc, inst}; inst_valid_o = not empty; head drives inst_o/inst_pc_o.
REQ-018 Pop SHALL occur when inst_valid_o=1 and stall_i=0 and jump_i=0.
REQ-019 Fetch "needs port" SHALL be true when jump_i=0 and (count<2 or pop this cycle).
REQ-020 Debug SHALL be granted when dbg_req_i=1 and (fetch does not need port, or count>=1 and previous-cycle owner was fetch); otherwise fetch owns port if it needs it.
REQ-021 rom_addr_o SHALL be dbg_addr_i when dbg_gnt_o=1, else fetch_pc.
REQ-022 On fetch ownership, {fetch_pc, rom_inst_i} SHALL be written to FIFO tail and fetch_pc += 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
REQ-023 Simultaneous pop and push at count=2 or count=1 SHALL keep count unchanged, order preserved.
REQ-024 On jump_i=1: FIFO flushed (count=0, inst_valid_o=0 next cycle), fetch_pc <= {jump_addr_i[31:2],2'b00}, no fetch write that cycle; flush overrides stall_i and pop.
REQ-025 Debug grant SHALL remain permitted in a jump cycle (fetch does not need port).
REQ-026 Debug read latency SHALL be 1 cycle: dbg_rvalid_o=1 and dbg_rdata_o=rom_inst_i(registered) in the cycle after dbg_gnt_o=1; dbg_rvalid_o=0 otherwise, dbg_rdata_o holds last value.
REQ-027 Previous-cycle owner register SHALL update only in cycles where the port is used (fetch or debug).
REQ-028 Fetch SHALL never be starved more than 1 consecutive cycle while dbg_req_i is held; debug SHALL be granted within 2 cycles of request under continuous fetch.

Reset
REQ-029 rst_n=0 SHALL immediately clear: FIFO count=0, inst_valid_o=0, dbg_rvalid_o=0, dbg_rdata_o=0, fetch_pc=RESET_PC, previous owner=fetch.
REQ-030 Reset mid-operation SHALL discard buffered instructions and any pending debug response; first fetch after release from RESET_PC.
REQ-031 dbg_gnt_o SHALL be 0 while rst_n=0; rom_addr_o = RESET_PC.

Configuration
REQ-032 Macro ROM_FETCH_DBG_EN defined: debug arbitration per REQ-020..REQ-028.
REQ-033 Macro ROM_FETCH_DBG_EN undefined: ports retained; dbg_gnt_o=0, dbg_rvalid_o=0, dbg_rdata_o=0 constant; fetch owns port always; no debug state flops.

Verification
REQ-034 Reset release, stall_i=0, ROM words W0..W3 at 0x0..0xC -> inst_valid_o from cycle 2, inst_pc_o sequence 0x0,0x4,0x8,0xC with matching inst_o.
REQ-035 stall_i=1 for 5 cycles -> count saturates at 2, fetch_pc stops at 0x8, rom_addr_o hold; release -> 0x0,0x4,0x8 delivered in order, no gap.
REQ-036 jump_i=1, jump_addr_i=0x23 with stall_i=1 and count=2 -> next cycle inst_valid_o=0; following cycles inst_pc_o=0x20,0x24.
REQ-037 dbg_req_i held, dbg_addr_i=0x10, continuous fetch -> grants alternate fetch/debug; dbg_rvalid_o=1 with ROM[0x10] one cycle after each grant.
REQ-038 rst_n low mid-stream with count=2 and dbg grant in flight -> outputs cleared asynchronously, no dbg_rvalid_o after release, first inst_pc_o=RESET_PC.
REQ-039 Build without ROM_FETCH_DBG_EN, dbg_req_i=1 constant -> dbg_gnt_o=0, dbg_rvalid_o=0, fetch sequence identical to REQ-034.
